// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D) requesters, one transaction at a time.
// Ack arrives 3 cycles after a request is sampled with a zero-wait memory; requesters hold req until ack.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int TIMEOUT      = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [31:0]   i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_wstrb,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic          owner_d
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [SW-1:0] d_streak;
  logic [TW-1:0] tcnt;
  logic          grant_d;
  logic          done_ok;
  logic          done_to;

  always_comb begin
    grant_d = d_req && !(i_req && (d_streak == STREAK_MAX));
    done_ok = (state == S_WAIT) && mem_rvalid;
    // A real response in the last allowed cycle beats the timeout.
    done_to = !done_ok && ((state == S_ISSUE) || (state == S_WAIT)) && (tcnt == TCNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      d_streak  <= '0;
      tcnt      <= '0;
      i_ack     <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'h0;
      busy      <= 1'b0;
      owner_d   <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req || d_req) begin
            state   <= S_ISSUE;
            busy    <= 1'b1;
            mem_req <= 1'b1;
            tcnt    <= '0;
            owner_d <= grant_d;
            if (grant_d) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_wstrb <= d_we ? d_wstrb : 4'h0;
              if (!i_req)
                d_streak <= '0;
              else if (d_streak != STREAK_MAX)
                d_streak <= d_streak + 1'b1;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              mem_wstrb <= 4'h0;
              d_streak  <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (!done_to) begin
            tcnt <= tcnt + 1'b1;
            if (mem_ready) begin
              mem_req <= 1'b0;
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!done_ok && !done_to)
            tcnt <= tcnt + 1'b1;
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (done_ok || done_to) begin
        state   <= S_RESP;
        mem_req <= 1'b0;
        if (owner_d) begin
          d_ack   <= 1'b1;
          d_rdata <= done_ok ? mem_rdata : 32'h0;
          d_err   <= done_to;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= done_ok ? mem_rdata : 32'h0;
          i_err   <= done_to;
        end
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the core's fetch path (I-port) and load/store path (D-port).
- Runs one transaction at a time through a 4-state FSM.
- D-port has priority, with a starvation guard for fetch.
- A timeout returns an error to the requester if the memory never responds.

Parameters:
AW, 32, address width of all ports
TIMEOUT, 16, max cycles spent in ISSUE+WAIT before a forced error response (>=2)
STARVE_LIMIT, 3, max consecutive D grants while i_req is pending before I wins (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low (rst=0 resets on next rising edge)
i_req  in  1  fetch request, held until i_ack
i_addr  in  AW  fetch address, stable while i_req
i_ack  out  1  one-cycle completion pulse
i_rdata  out  32  fetch data, valid with i_ack
i_err  out  1  timeout flag, valid with i_ack
d_req  in  1  load/store request, held until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  AW  data address
d_wdata  in  32  store data
d_wstrb  in  4  byte enables for stores
d_ack  out  1  one-cycle completion pulse
d_rdata  out  32  load data, valid with d_ack
d_err  out  1  timeout flag, valid with d_ack
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  32  memory write data
mem_wstrb  out  4  memory byte enables (0 for reads)
mem_ready  in  1  memory accepted request this cycle
mem_rvalid  in  1  memory response this cycle (reads and writes)
mem_rdata  in  32  memory read data, valid with mem_rvalid
busy  out  1  1 in any state except IDLE
owner_d  out  1  1 when the current or last transaction is D

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE. All outputs are 0: acks, errs, rdata, mem_* and busy. Streak and timeout counters clear. An in-flight memory transaction is abandoned.
- All outputs are registered.
- States are IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Samples i_req and d_req.
  - Only one request high: grant it.
  - Both high: grant D, unless d_streak==STARVE_LIMIT, in which case grant I.
  - On grant, latch we/addr/wdata/wstrb into the mem_* registers (for I: we=0, wstrb=0). Set owner_d and go to ISSUE.
- ISSUE: mem_req=1. When mem_ready=1 is sampled, drop mem_req and go to WAIT.
- WAIT: when mem_rvalid=1 is sampled, capture mem_rdata and go to RESP. mem_rvalid is ignored in every other state; late or stray responses are discarded.
- RESP:
  - The owner's ack=1 for exactly one cycle, with rdata and err.
  - For D stores, d_rdata is the captured mem_rdata and carries no meaning.
  - Next state is IDLE.
  - The requester deasserts req at the edge after it sees ack. IDLE does not sample until the cycle after RESP, so a stale req is never re-granted.
- rdata/err outputs hold their value between acks. The ack of the non-owner stays 0.
- Minimum latency: req high at edge 0 -> ISSUE -> mem_ready at edge 1 -> WAIT -> mem_rvalid at edge 2 -> ack high in cycle 3. Memory must not assert mem_rvalid in the acceptance cycle.
- Timeout:
  - A counter clears when ISSUE is entered and increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT-1 without completion, go to RESP with err=1 and rdata=0. mem_req drops immediately.
- Starvation counter d_streak (width clog2(STARVE_LIMIT+1), saturating):
  - On a D grant with i_req=1: +1.
  - On a D grant with i_req=0: cleared to 0.
  - On an I grant: cleared to 0.
- Simultaneous mem_ready and mem_rvalid while in ISSUE: only mem_ready acts; rvalid is ignored.
- Requests arriving while busy are not acknowledged until later service; the input contract requires them to be held.

Test Plan:
1. I-only read: i_req=1, i_addr=0x0, mem_ready immediate, mem_rvalid next cycle with mem_rdata=0x00000093 -> i_ack pulse in cycle 3, i_rdata=0x00000093, i_err=0, d_ack=0, mem_we=0.
2. Collision: i_req and d_req rise together (d_addr=0x100 load) -> D served first (mem_addr=0x100, d_ack), then I (mem_addr=0x0, i_ack). Order is D, I.
3. Starvation, STARVE_LIMIT=3: d_req held high with a fresh store each time, i_req held high -> grant order D, D, D, I, D.
4. Store: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=0xF -> mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF, mem_wstrb=0xF while mem_req; one d_ack, d_err=0.
5. Timeout: i_req=1, mem_ready stays 0 -> mem_req high for 16 cycles, then i_ack=1, i_err=1, i_rdata=0. A mem_rvalid injected 2 cycles later causes no ack.
6. Reset mid-WAIT: rst=0 for one edge -> all outputs 0, busy=0. After release, a new d_req load completes normally with 3-cycle latency.
